power_rst_sequencer: RTL

Power/reset sequencer for a bank of clocked gate-level IC models. It enables NRAIL supply rails in order with programmable spacing and holds the components' shared reset for a settle period before releasing it. Orderly shutdown runs in reverse; a fault forces an immediate drop. Its outputs drive the `vcc` and `rst` inputs of the IC models, whose outputs are held while `rst` is high or `vcc` is low.

---
 rtl/pwr_seq_pkg.sv | 23 ++
 rtl/seq_timer.sv | 24 ++
 rtl/power_rst_sequencer.sv | 132 +++++++++++++
 3 files changed

// File: rtl/pwr_seq_pkg.sv
// Shared types and default constants for the power/reset sequencer.
package pwr_seq_pkg;

  typedef enum logic [2:0] {
    OFF  = 3'd0,
    RAMP = 3'd1,
    HOLD = 3'd2,
    ON   = 3'd3,
    DOWN = 3'd4
  } pwr_state_e;

  localparam int NRAIL_DEF    = 4;
  localparam int RAIL_DLY_DEF = 16;
  localparam int RST_HOLD_DEF = 8;
  localparam int DOWN_DLY_DEF = 4;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/seq_timer.sv
// Loadable up-counter with terminal-count compare and synchronous clear.
module seq_timer #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          load,
  input  logic          en,
  input  logic [CW-1:0] load_val,
  input  logic [CW-1:0] tc_val,
  output logic [CW-1:0] cnt,
  output logic          tc
);

  always_ff @(posedge clk) begin
    if (rst || clr)  cnt <= '0;
    else if (load)   cnt <= load_val;
    else if (en)     cnt <= cnt + CW'(1);
  end

  assign tc = (cnt == tc_val);

endmodule

// File: rtl/power_rst_sequencer.sv
// Rail-by-rail power-up, reset hold, reverse-order shutdown and emergency drop.
// Define PWR_SEQ_FAULT_LATCH_EN to make fault_flag sticky until fault_clr.
module power_rst_sequencer
  import pwr_seq_pkg::*;
#(
  parameter int NRAIL    = NRAIL_DEF,
  parameter int RAIL_DLY = RAIL_DLY_DEF,
  parameter int RST_HOLD = RST_HOLD_DEF,
  parameter int DOWN_DLY = DOWN_DLY_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwr_req,
  input  logic             fault,
  input  logic             fault_clr,
  output logic [NRAIL-1:0] vcc_en,
  output logic             comp_rst,
  output logic             pwr_good,
  output logic             fault_flag,
  output logic [2:0]       state
);

  localparam int CW = $clog2(max3(RAIL_DLY, RST_HOLD, DOWN_DLY) + 1);
  localparam int IW = (NRAIL > 1) ? $clog2(NRAIL) : 1;

  pwr_state_e    st;
  logic [IW-1:0] idx;
  logic [CW-1:0] tc_val, cnt;
  logic          tc, tmr_clr, start_ok;

  // Any edge that changes state or rail index must also restart the timer.
  always_comb begin
    tc_val = CW'(RAIL_DLY - 1);
    case (st)
      HOLD:    tc_val = CW'(RST_HOLD - 1);
      DOWN:    tc_val = CW'(DOWN_DLY - 1);
      default: tc_val = CW'(RAIL_DLY - 1);
    endcase
    tmr_clr = (st == OFF) || (st == ON) || fault || tc || (!pwr_req && st != DOWN);
  end

  seq_timer #(.CW(CW)) u_tmr (
    .clk      (clk),
    .rst      (rst),
    .clr      (tmr_clr),
    .load     (1'b0),
    .en       (1'b1),
    .load_val ('0),
    .tc_val   (tc_val),
    .cnt      (cnt),
    .tc       (tc)
  );

`ifdef PWR_SEQ_FAULT_LATCH_EN
  assign start_ok = !fault_flag;
`else
  logic unused_fault_clr;
  assign unused_fault_clr = fault_clr;
  assign start_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= OFF;
      idx        <= '0;
      vcc_en     <= '0;
      comp_rst   <= 1'b1;
      pwr_good   <= 1'b0;
      fault_flag <= 1'b0;
    end else begin
`ifdef PWR_SEQ_FAULT_LATCH_EN
      if (fault)          fault_flag <= 1'b1;
      else if (fault_clr) fault_flag <= 1'b0;
`else
      fault_flag <= fault;
`endif
      if (fault && st != OFF) begin
        st       <= OFF;
        idx      <= '0;
        vcc_en   <= '0;
        comp_rst <= 1'b1;
        pwr_good <= 1'b0;
      end else begin
        case (st)
          OFF: begin
            vcc_en   <= '0;
            comp_rst <= 1'b1;
            pwr_good <= 1'b0;
            if (pwr_req && !fault && start_ok) begin
              st     <= RAMP;
              idx    <= '0;
              vcc_en <= NRAIL'(1);
            end
          end
          RAMP, HOLD, ON: begin
            if (!pwr_req) begin
              // idx already names the highest enabled rail
              st       <= DOWN;
              comp_rst <= 1'b1;
              pwr_good <= 1'b0;
            end else if (tc && st == RAMP) begin
              if (idx == IW'(NRAIL - 1)) begin
                st <= HOLD;
              end else begin
                idx    <= idx + IW'(1);
                vcc_en <= vcc_en | (NRAIL'(2) << idx);
              end
            end else if (tc && st == HOLD) begin
              st       <= ON;
              comp_rst <= 1'b0;
              pwr_good <= 1'b1;
            end
          end
          DOWN: begin
            if (tc) begin
              vcc_en <= vcc_en & ~(NRAIL'(1) << idx);
              if (idx == '0) st <= OFF;
              else           idx <= idx - IW'(1);
            end
          end
          default: begin
            st     <= OFF;
            vcc_en <= '0;
          end
        endcase
      end
    end
  end

  assign state = st;

endmodule
